// File: rtl/ir_remote_pkg.sv
// Shared types, timing windows (in 10 us ticks) and NEC command codes for the IR colour remote.
// Consumers: ir_nec_rx and ir_color_ctrl.
package ir_remote_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEAD_LO = 3'd1,
    LEAD_HI = 3'd2,
    BIT_LO  = 3'd3,
    BIT_HI  = 3'd4,
    STOP_LO = 3'd5,
    RPT_LO  = 3'd6
  } ir_state_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  localparam logic [10:0] DUR_MAX       = 11'd2047;
  localparam logic [10:0] TIMEOUT_TICKS = 11'd1100;
  localparam logic [10:0] LEAD_LO_MIN   = 11'd800;
  localparam logic [10:0] LEAD_LO_MAX   = 11'd1000;
  localparam logic [10:0] LEAD_HI_MIN   = 11'd400;
  localparam logic [10:0] LEAD_HI_MAX   = 11'd500;
  localparam logic [10:0] RPT_HI_MIN    = 11'd200;
  localparam logic [10:0] RPT_HI_MAX    = 11'd260;
  localparam logic [10:0] PULSE_MIN     = 11'd40;
  localparam logic [10:0] PULSE_MAX     = 11'd70;
  localparam logic [10:0] ONE_MIN       = 11'd150;
  localparam logic [10:0] ONE_MAX       = 11'd190;

  localparam logic [7:0] CMD_R_UP = 8'h0C;
  localparam logic [7:0] CMD_R_DN = 8'h08;
  localparam logic [7:0] CMD_G_UP = 8'h18;
  localparam logic [7:0] CMD_G_DN = 8'h1C;
  localparam logic [7:0] CMD_B_UP = 8'h5E;
  localparam logic [7:0] CMD_B_DN = 8'h5A;
  localparam logic [7:0] CMD_OFF  = 8'h45;
  localparam logic [7:0] CMD_FULL = 8'h47;

  function automatic logic in_win(input logic [10:0] d, input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  function automatic logic [2:0] lvl_up(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  function automatic logic [2:0] lvl_dn(input logic [2:0] v);
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction

  function automatic logic is_updn(input logic [7:0] c);
    case (c)
      CMD_R_UP, CMD_R_DN, CMD_G_UP, CMD_G_DN, CMD_B_UP, CMD_B_DN: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Word is LSB-first: [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd.
  function automatic logic frame_check(input logic [31:0] w, input logic [7:0] addr);
    return (w[7:0] == addr) && (w[15:8] == ~w[7:0]) && (w[31:24] == ~w[23:16]);
  endfunction

  function automatic rgb_t apply_cmd(input logic [7:0] c, input rgb_t cur);
    rgb_t nxt;
    nxt = cur;
    case (c)
      CMD_R_UP: nxt.r = lvl_up(cur.r);
      CMD_R_DN: nxt.r = lvl_dn(cur.r);
      CMD_G_UP: nxt.g = lvl_up(cur.g);
      CMD_G_DN: nxt.g = lvl_dn(cur.g);
      CMD_B_UP: nxt.b = lvl_up(cur.b);
      CMD_B_DN: nxt.b = lvl_dn(cur.b);
      CMD_OFF:  nxt = '{r: 3'd0, g: 3'd0, b: 3'd0};
      CMD_FULL: nxt = '{r: 3'd7, g: 3'd7, b: 3'd7};
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ir_nec_rx.sv
// NEC frame receiver: input synchronizer, tick prescaler, pulse-width FSM and frame check.
// Event outputs are single-cycle combinational strobes; the consumer registers them.
module ir_nec_rx
  import ir_remote_pkg::*;
#(
  parameter int          CLK_DIV = 100,
  parameter logic [7:0]  ADDR    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_in,
  output logic       frame_ok,
  output logic       frame_bad,
  output logic [7:0] frame_cmd,
  output logic       rpt_ok
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [2:0]       sync_q;
  logic             rise_s, fall_s, edge_s, tick_s;
  logic [PRE_W-1:0] pre_q;
  logic [10:0]      dur_q;
  ir_state_e        state_q, state_d;
  logic [5:0]       nbit_q, nbit_d;
  logic [31:0]      shift_q, shift_d;

  // Idle-high reset value avoids a spurious falling edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 3'b111;
    else     sync_q <= {sync_q[1:0], ir_in};
  end

  assign rise_s = sync_q[1] & ~sync_q[2];
  assign fall_s = ~sync_q[1] & sync_q[2];
  assign edge_s = rise_s | fall_s;
  assign tick_s = (pre_q == PRE_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pre_q <= '0;
    else if (tick_s) pre_q <= '0;
    else             pre_q <= pre_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               dur_q <= 11'd0;
    else if (edge_s)                       dur_q <= 11'd0;
    else if (tick_s && (dur_q != DUR_MAX)) dur_q <= dur_q + 11'd1;
    else                                   dur_q <= dur_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      nbit_q  <= 6'd0;
      shift_q <= 32'd0;
    end else begin
      state_q <= state_d;
      nbit_q  <= nbit_d;
      shift_q <= shift_d;
    end
  end

  // Timeout outranks a coincident edge, which is then ignored.
  always_comb begin
    state_d   = state_q;
    nbit_d    = nbit_q;
    shift_d   = shift_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    rpt_ok    = 1'b0;
    if ((state_q != IDLE) && (dur_q >= TIMEOUT_TICKS)) begin
      state_d = IDLE;
    end else if (edge_s) begin
      state_d = IDLE;
      case (state_q)
        IDLE: begin
          if (fall_s) state_d = LEAD_LO;
          else        state_d = IDLE;
        end
        LEAD_LO: begin
          if (rise_s && in_win(dur_q, LEAD_LO_MIN, LEAD_LO_MAX)) state_d = LEAD_HI;
          else                                                   state_d = IDLE;
        end
        LEAD_HI: begin
          if (fall_s && in_win(dur_q, LEAD_HI_MIN, LEAD_HI_MAX)) begin
            state_d = BIT_LO;
            nbit_d  = 6'd0;
          end else if (fall_s && in_win(dur_q, RPT_HI_MIN, RPT_HI_MAX)) begin
            state_d = RPT_LO;
          end else begin
            state_d = IDLE;
          end
        end
        BIT_LO: begin
          if (rise_s && in_win(dur_q, PULSE_MIN, PULSE_MAX)) state_d = BIT_HI;
          else                                               state_d = IDLE;
        end
        BIT_HI: begin
          if (fall_s && (in_win(dur_q, PULSE_MIN, PULSE_MAX) || in_win(dur_q, ONE_MIN, ONE_MAX))) begin
            shift_d = {in_win(dur_q, ONE_MIN, ONE_MAX), shift_q[31:1]};
            nbit_d  = nbit_q + 6'd1;
            state_d = (nbit_q == 6'd31) ? STOP_LO : BIT_LO;
          end else begin
            state_d = IDLE;
          end
        end
        STOP_LO: begin
          if (rise_s && in_win(dur_q, PULSE_MIN, PULSE_MAX)) begin
            frame_ok  = frame_check(shift_q, ADDR);
            frame_bad = ~frame_check(shift_q, ADDR);
          end else begin
            frame_ok  = 1'b0;
          end
        end
        RPT_LO: begin
          if (rise_s && in_win(dur_q, PULSE_MIN, PULSE_MAX)) rpt_ok = 1'b1;
          else                                               rpt_ok = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign frame_cmd = shift_q[23:16];

endmodule

// File: rtl/ir_color_ctrl.sv
// IR remote colour controller: registered r/g/b levels driven by decoded NEC commands.
// Optional macro IR_REPEAT_EN makes repeat codes re-apply the last UP/DN command.
module ir_color_ctrl
  import ir_remote_pkg::*;
#(
  parameter int         CLK_DIV = 100,
  parameter logic [7:0] ADDR    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_in,
  output logic [2:0] r,
  output logic [2:0] g,
  output logic [2:0] b,
  output logic [7:0] cmd,
  output logic       cmd_valid
);

  logic       frame_ok_s, frame_bad_s, rpt_ok_s;
  logic [7:0] frame_cmd_s;
  rgb_t       rgb_q, rgb_d;
  logic [7:0] cmd_q, cmd_d;
  logic       valid_q, valid_d;

  ir_nec_rx #(
    .CLK_DIV (CLK_DIV),
    .ADDR    (ADDR)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ir_in     (ir_in),
    .frame_ok  (frame_ok_s),
    .frame_bad (frame_bad_s),
    .frame_cmd (frame_cmd_s),
    .rpt_ok    (rpt_ok_s)
  );

`ifdef IR_REPEAT_EN
  logic last_ok_q, last_ok_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_ok_q <= 1'b0;
    else     last_ok_q <= last_ok_d;
  end
`else
  // Repeat and reject events carry no meaning without repeat support.
  logic unused_evt_s;
  assign unused_evt_s = rpt_ok_s | frame_bad_s;
`endif

  always_comb begin
    rgb_d   = rgb_q;
    cmd_d   = cmd_q;
    valid_d = 1'b0;
`ifdef IR_REPEAT_EN
    last_ok_d = last_ok_q;
`endif
    if (frame_ok_s) begin
      cmd_d   = frame_cmd_s;
      valid_d = 1'b1;
      rgb_d   = apply_cmd(frame_cmd_s, rgb_q);
`ifdef IR_REPEAT_EN
      last_ok_d = 1'b1;
`endif
    end
`ifdef IR_REPEAT_EN
    else if (frame_bad_s) begin
      last_ok_d = 1'b0;
    end else if (rpt_ok_s && last_ok_q && is_updn(cmd_q)) begin
      valid_d = 1'b1;
      rgb_d   = apply_cmd(cmd_q, rgb_q);
    end
`endif
    else begin
      valid_d = 1'b0;
    end
  end

  // All outputs move together on one edge so the strip never sees a partial update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q   <= '{r: 3'd0, g: 3'd0, b: 3'd0};
      cmd_q   <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
    end
  end

  assign r         = rgb_q.r;
  assign g         = rgb_q.g;
  assign b         = rgb_q.b;
  assign cmd       = cmd_q;
  assign cmd_valid = valid_q;

endmodule
